// File: rtl/oai33_bist_checker_pkg.sv
// Shared types and constants for the oai33 cell self-test harness.
// Holds the FSM state encoding, pattern geometry and the reference cell function.
package oai33_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } bist_state_t;

    localparam int               PAT_W            = 6;
    localparam logic [PAT_W-1:0] PAT_LAST         = 6'd63;
    localparam logic [15:0]      SIG_POLY_DEFAULT = 16'h100B;

    // Golden oai33: pat[2:0] drive A1..A3, pat[5:3] drive B1..B3.
    function automatic logic oai33_expected(input logic [PAT_W-1:0] pat);
        return ~((|pat[2:0]) & (|pat[5:3]));
    endfunction

endpackage

// File: rtl/oai33_bist_checker_if.sv
// Stimulus, response and status bundle between the self-test harness and its wrapper.
// The master side is the harness; the slave side is the cell/wrapper that observes it.
interface oai33_bist_if #(
    parameter int ERR_W = 7,
    parameter int SIG_W = 16
);
    logic             start;
    logic             zn;
    logic             a1, a2, a3;
    logic             b1, b2, b3;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] errCnt;
    logic [SIG_W-1:0] signature;

    modport master (
        input  start, zn,
        output a1, a2, a3, b1, b2, b3, busy, done, pass, errCnt, signature
    );

    modport slave (
        output start, zn,
        input  a1, a2, a3, b1, b2, b3, busy, done, pass, errCnt, signature
    );
endinterface

// File: rtl/oai33_bist_checker_misr.sv
// Serial-input MISR that compacts the sampled ZN stream into a signature.
// Clear has priority over enable so a new run always starts from zero.
module oai33_bist_misr
    import oai33_bist_pkg::*;
#(
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEFAULT)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_din,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= {r_sig[SIG_W-2:0], 1'b0}
                   ^ (r_sig[SIG_W-1] ? SIG_POLY : '0)
                   ^ {{(SIG_W-1){1'b0}}, i_din};
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/oai33_bist_checker.sv
// Built-in self-test harness for the 7-track 5V oai33 cell: sweeps all 64 input
// patterns, samples ZN after a settle window, counts mismatches and builds a MISR signature.
module oai33_bist_checker
    import oai33_bist_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 2,
    parameter int               ERR_W         = 7,
    parameter int               SIG_W         = 16,
    parameter logic [SIG_W-1:0] SIG_POLY      = SIG_W'(SIG_POLY_DEFAULT)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    oai33_bist_if.master   bist,
    inout  wire            io_vdd,
    inout  wire            io_vss
);

    localparam int                  SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0]    ERR_MAX     = '1;

    bist_state_t         r_state;
    bist_state_t         w_nextState;
    logic [PAT_W-1:0]    r_pat;
    logic [SETTLE_W-1:0] r_settle;
    logic [ERR_W-1:0]    r_errCnt;
    logic                w_startRun;
    logic                w_mismatch;
    logic                w_sampleEn;

    // Supply pins exist only so the harness drops into cell-library wrappers.
    wire w_unusedSupply = io_vdd ^ io_vss;

    assign w_startRun = bist.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_sampleEn = (r_state == SAMPLE);
    assign w_mismatch = (bist.zn !== oai33_expected(r_pat));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE: if (bist.start) w_nextState = WAIT;
            WAIT:       if (r_settle == SETTLE_LAST) w_nextState = SAMPLE;
            SAMPLE:     w_nextState = (r_pat == PAT_LAST) ? DONE : WAIT;
            default:    w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_pat    <= '0;
            r_settle <= '0;
            r_errCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_startRun) begin
                r_pat    <= '0;
                r_settle <= '0;
                r_errCnt <= '0;
            end else if (r_state == WAIT) begin
                r_settle <= r_settle + 1'b1;
            end else if (r_state == SAMPLE) begin
                if (w_mismatch && (r_errCnt != ERR_MAX)) begin
                    r_errCnt <= r_errCnt + 1'b1;
                end
                // The last pattern stays on the pins through DONE.
                if (r_pat != PAT_LAST) begin
                    r_pat    <= r_pat + 1'b1;
                    r_settle <= '0;
                end
            end
        end
    end

    oai33_bist_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_startRun),
        .i_en    (w_sampleEn),
        .i_din   (bist.zn),
        .o_sig   (bist.signature)
    );

    assign bist.a1     = r_pat[0];
    assign bist.a2     = r_pat[1];
    assign bist.a3     = r_pat[2];
    assign bist.b1     = r_pat[3];
    assign bist.b2     = r_pat[4];
    assign bist.b3     = r_pat[5];
    assign bist.busy   = (r_state == WAIT) || (r_state == SAMPLE);
    assign bist.done   = (r_state == DONE);
    assign bist.pass   = (r_state == DONE) && (r_errCnt == '0);
    assign bist.errCnt = r_errCnt;

endmodule

// File: tb/tb_oai33_bist_checker.sv
// Randomized self-checking bench for oai33_bist_checker: two harness instances
// (settle 2 / 7-bit counter and settle 1 / 3-bit counter) against a behavioural cell model.
module tb_oai33_bist_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        startA;
    logic        startB;
    int          zMode;
    logic [63:0] zMask;
    int          total;
    int          bad;

    wire vdd = 1'b1;
    wire vss = 1'b0;

    always #5 clk = ~clk;

    oai33_bist_if #(.ERR_W(7), .SIG_W(16)) bistA ();
    oai33_bist_if #(.ERR_W(3), .SIG_W(16)) bistB ();

    logic [5:0] idxA;
    logic [5:0] idxB;

    assign idxA = {bistA.b3, bistA.b2, bistA.b1, bistA.a3, bistA.a2, bistA.a1};
    assign idxB = {bistB.b3, bistB.b2, bistB.b1, bistB.a3, bistB.a2, bistB.a1};

    // Cell under test: zMode 0 = oai33 with optional per-pattern faults, 1 = stuck-at-1, 2 = stuck-at-0.
    assign bistA.start = startA;
    assign bistB.start = startB;
    assign bistA.zn = (zMode == 1) ? 1'b1 : (zMode == 2) ? 1'b0 :
                      (~((|idxA[2:0]) & (|idxA[5:3])) ^ zMask[idxA]);
    assign bistB.zn = (zMode == 1) ? 1'b1 : (zMode == 2) ? 1'b0 :
                      (~((|idxB[2:0]) & (|idxB[5:3])) ^ zMask[idxB]);

    oai33_bist_checker #(
        .SETTLE_CYCLES (2),
        .ERR_W         (7),
        .SIG_W         (16),
        .SIG_POLY      (16'h100B)
    ) dutA (
        .i_clk  (clk),
        .i_rst  (rst),
        .bist   (bistA.master),
        .io_vdd (vdd),
        .io_vss (vss)
    );

    oai33_bist_checker #(
        .SETTLE_CYCLES (1),
        .ERR_W         (3),
        .SIG_W         (16),
        .SIG_POLY      (16'h100B)
    ) dutB (
        .i_clk  (clk),
        .i_rst  (rst),
        .bist   (bistB.master),
        .io_vdd (vdd),
        .io_vss (vss)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
        end
    endtask

    // which: 0 busy, 1 done, 2 pass, 3 errCnt, 4 signature, 5 stimulus pins
    function automatic logic [31:0] stat(input int sel, input int which);
        logic [31:0] v;
        v = '0;
        if (sel == 0) begin
            case (which)
                0: v = {31'd0, bistA.busy};
                1: v = {31'd0, bistA.done};
                2: v = {31'd0, bistA.pass};
                3: v = {25'd0, bistA.errCnt};
                4: v = {16'd0, bistA.signature};
                default: v = {26'd0, idxA};
            endcase
        end else begin
            case (which)
                0: v = {31'd0, bistB.busy};
                1: v = {31'd0, bistB.done};
                2: v = {31'd0, bistB.pass};
                3: v = {29'd0, bistB.errCnt};
                4: v = {16'd0, bistB.signature};
                default: v = {26'd0, idxB};
            endcase
        end
        return v;
    endfunction

    task automatic setStart(input int sel, input logic v);
        if (sel == 0) startA = v;
        else          startB = v;
    endtask

    // Reference: walk the 64 patterns in order, compare each against the oai33 truth table.
    task automatic modelRun(input int mode, input logic [63:0] mask, input int errW,
                            output int err, output logic [15:0] sig);
        bit a, b, ideal, z, fb;
        err = 0;
        sig = 16'h0;
        for (int i = 0; i < 64; i++) begin
            a     = (i % 8) != 0;
            b     = (i / 8) != 0;
            ideal = !(a && b);
            z     = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (ideal ^ mask[i]);
            if (z != ideal && err < (1 << errW) - 1) err++;
            fb  = sig[15];
            sig = (sig << 1) ^ (fb ? 16'h100B : 16'h0) ^ {15'd0, z};
        end
    endtask

    // One run: START pulse, optional stray START at cycle extraAt, optional RST at cycle rstAt.
    task automatic applyStimulus(input int sel, input int extraAt, input int rstAt,
                                 output int cycles, output int busyLow,
                                 output logic [31:0] errAtStart, output logic [31:0] sigAtStart);
        cycles  = -2;
        @(negedge clk);
        setStart(sel, 1'b1);
        @(posedge clk);
        #1;
        setStart(sel, 1'b0);
        errAtStart = stat(sel, 3);
        sigAtStart = stat(sel, 4);
        busyLow    = (stat(sel, 0) == 32'd1) ? 0 : 1;
        for (int n = 1; n <= 2000; n++) begin
            setStart(sel, n == extraAt);
            if (n == rstAt) rst = 1'b1;
            @(posedge clk);
            #1;
            if (n == rstAt) begin
                rst    = 1'b0;
                cycles = -1;
                setStart(sel, 1'b0);
                return;
            end
            if (stat(sel, 1) == 32'd1) begin
                cycles = n;
                break;
            end
            if (stat(sel, 0) != 32'd1) busyLow++;
        end
        setStart(sel, 1'b0);
    endtask

    task automatic doRun(input int sel, input int mode, input logic [63:0] mask,
                         input int extraAt, input int expCycles, input string tag,
                         output logic [15:0] sigOut);
        int          cycles, busyLow, expErr;
        logic [31:0] errAtStart, sigAtStart;
        logic [15:0] expSig;
        zMode = mode;
        zMask = mask;
        modelRun(mode, mask, (sel == 0) ? 7 : 3, expErr, expSig);
        applyStimulus(sel, extraAt, 0, cycles, busyLow, errAtStart, sigAtStart);
        checkOutput({tag, " cycles"}, cycles, expCycles);
        checkOutput({tag, " busyLow"}, busyLow, 0);
        checkOutput({tag, " errCleared"}, errAtStart, 0);
        checkOutput({tag, " sigCleared"}, sigAtStart, 0);
        checkOutput({tag, " done"}, stat(sel, 1), 1);
        checkOutput({tag, " busyEnd"}, stat(sel, 0), 0);
        checkOutput({tag, " pass"}, stat(sel, 2), (expErr == 0) ? 1 : 0);
        checkOutput({tag, " errCnt"}, stat(sel, 3), expErr);
        checkOutput({tag, " signature"}, stat(sel, 4), {16'd0, expSig});
        checkOutput({tag, " pinsHeld"}, stat(sel, 5), 63);
        sigOut = stat(sel, 4) & 32'hFFFF;
    endtask

    initial begin
        int          cycles, busyLow;
        logic [31:0] errAtStart, sigAtStart;
        logic [15:0] sigA, sigB1, sigB2;
        logic [63:0] mask;

        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        zMode  = 0;
        zMask  = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busyA", stat(0, 0), 0);
        checkOutput("reset doneA", stat(0, 1), 0);
        checkOutput("reset passA", stat(0, 2), 0);
        checkOutput("reset errA", stat(0, 3), 0);
        checkOutput("reset sigA", stat(0, 4), 0);
        checkOutput("reset pinsA", stat(0, 5), 0);
        checkOutput("reset busyB", stat(1, 0), 0);
        checkOutput("reset doneB", stat(1, 1), 0);
        @(negedge clk);
        rst = 1'b0;

        doRun(0, 0, 64'd0, 0, 192, "goodA", sigA);
        doRun(0, 1, 64'd0, 0, 192, "stuck1A", sigA);
        checkOutput("stuck1A err49", stat(0, 3), 49);
        doRun(0, 2, 64'd0, 0, 192, "stuck0A", sigA);
        checkOutput("stuck0A err15", stat(0, 3), 15);
        checkOutput("stuck0A sig0", stat(0, 4), 0);

        for (int k = 0; k < 3; k++) begin
            mask = {$urandom & $urandom, $urandom & $urandom};
            doRun(0, 0, mask, 0, 192, $sformatf("randA%0d", k), sigA);
        end
        mask = {$urandom & $urandom, $urandom & $urandom};
        doRun(0, 0, mask, 50, 192, "strayStartA", sigA);

        doRun(1, 1, 64'd0, 0, 128, "stuck1B", sigB1);
        checkOutput("stuck1B saturate7", stat(1, 3), 7);
        doRun(1, 0, 64'd0, 0, 128, "goodB1", sigB1);
        doRun(1, 0, 64'd0, 0, 128, "goodB2", sigB2);
        checkOutput("goodB repeatSig", {16'd0, sigB2}, {16'd0, sigB1});
        mask = {$urandom, $urandom};
        doRun(1, 0, mask, 0, 128, "randB", sigB2);

        // Reset 100 cycles into a run on A must drop everything back to idle values.
        zMode = 0;
        zMask = '0;
        applyStimulus(0, 0, 100, cycles, busyLow, errAtStart, sigAtStart);
        checkOutput("midRst aborted", cycles, 32'hFFFFFFFF);
        checkOutput("midRst busy", stat(0, 0), 0);
        checkOutput("midRst done", stat(0, 1), 0);
        checkOutput("midRst pass", stat(0, 2), 0);
        checkOutput("midRst err", stat(0, 3), 0);
        checkOutput("midRst sig", stat(0, 4), 0);
        checkOutput("midRst pins", stat(0, 5), 0);

        // Reset and START in the same cycle: reset wins.
        @(negedge clk);
        startA = 1'b1;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        startA = 1'b0;
        rst    = 1'b0;
        checkOutput("rstOverStart busy", stat(0, 0), 0);
        @(posedge clk);
        #1;
        checkOutput("rstOverStart stillIdle", stat(0, 0), 0);

        doRun(0, 0, 64'd0, 0, 192, "goodAfterRstA", sigA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
